// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load handshake.
// A new word can be taken on the last bit of the current one, so words stream without gaps.
module piso_serializer #(
   parameter int N         = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic         shift_en,
   input  logic         SI,
   output logic         SO,
   output logic         so_valid,
   output logic         so_last,
   output logic [N-1:0] Q_out
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]    state_reg, state_next;
   logic [N-1:0]  q_reg, q_next, q_shifted;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          so_bit;
   logic          in_shift;
   logic          at_last;
   logic          load_fire;

   // Shift direction only decides which end feeds SO and which end takes SI.
   generate
      if (LSB_FIRST) begin : g_lsb
         assign q_shifted = {SI, q_reg[N-1:1]};
         assign so_bit    = q_reg[0];
      end else begin : g_msb
         assign q_shifted = {q_reg[N-2:0], SI};
         assign so_bit    = q_reg[N-1];
      end
   endgenerate

   assign in_shift   = (state_reg == SHIFT);
   assign at_last    = in_shift && (cnt_reg == CNT_LAST);
   assign load_ready = !rst && (!in_shift || (at_last && shift_en));
   assign load_fire  = load_valid && load_ready;

   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      cnt_next   = cnt_reg;
      if (load_fire) begin
         q_next     = din;
         cnt_next   = '0;
         state_next = SHIFT;
      end else if (in_shift && shift_en) begin
         // The final bit still shifts, so Q_out shows the SI fill once idle.
         q_next = q_shifted;
         if (at_last) begin
            cnt_next   = '0;
            state_next = IDLE;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         q_reg     <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign SO       = in_shift & so_bit;
   assign so_valid = in_shift;
   assign so_last  = at_last;
   assign Q_out    = q_reg;

endmodule
